active_v_fifo: RTL and testbench
================================

// Module: active_v_fifo
// PURPOSE
// - Synchronous single-clock FIFO with registered (standard, non-FWFT) read port.
// - One parameterized core backs the three per-core pipeline buffers of the first-edge
//   read stage: active_v_id_fifo (DATA_WIDTH=V_ID_WIDTH, also used for the edge buffer),
//   active_v_value_fifo (DATA_WIDTH=V_VALUE_WIDTH) and push_flag_fifo (DATA_WIDTH=1).
// - prog_full provides early back-pressure (stage_full) so in-flight BRAM reads still fit.
// PARAMETERS
// - DATA_WIDTH        32  width of din/dout
// - ADDR_WIDTH        5   log2 of storage depth; DEPTH = 2**ADDR_WIDTH = 32 words
// - PROG_FULL_THRESH  24  occupancy at or above which prog_full is high (1..DEPTH-1)
// PORTS
// - clk        in   1            rising-edge clock
// - rst        in   1            synchronous, active-low reset
// - din        in   DATA_WIDTH   write data
// - wr_en      in   1            write request
// - rd_en      in   1            read request
// - dout       out  DATA_WIDTH   read data, registered
// - valid      out  1            dout holds a word popped on the previous edge
// - full       out  1            occupancy == DEPTH
// - empty      out  1            occupancy == 0
// - prog_full  out  1            occupancy >= PROG_FULL_THRESH
// BEHAVIOUR
// - Reset (rst==0 at posedge): count=0, wr/rd pointers=0, dout=0, valid=0. The outputs
//   are then empty=1, full=0 and prog_full=0. Storage contents are not cleared. Reset
//   overrides any same-cycle wr_en/rd_en.
// - Write accepted (wr_ok) = wr_en & ~full. Data is stored at wr_ptr, and wr_ptr increments
//   modulo DEPTH (natural wrap).
// - Read accepted (rd_ok) = rd_en & ~empty. At the edge, dout <= mem[rd_ptr], rd_ptr
//   increments, and valid <= 1. On any edge without rd_ok, valid <= 0 and dout holds.
// - Read latency: 1 cycle from the rd_en edge to dout/valid. A word written at edge N is
//   readable at edge N+1 (empty drops after edge N).
// - count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
// - full, empty and prog_full are combinational decodes of the registered count. They
//   change only after a clock edge, never combinationally from wr_en/rd_en.
// - Write while full: ignored, even if rd_en is high in the same cycle. No overwrite, no
//   error flag.
// - Read while empty: ignored, even if wr_en is high in the same cycle. valid=0 and dout
//   holds.
// - Simultaneous wr_ok and rd_ok (0<count<DEPTH): both happen; the read returns the oldest
//   word and count is unchanged.
// - Order is strict FIFO. No data is lost or duplicated across pointer wrap.
// - prog_full uses a single threshold: it asserts when count >= PROG_FULL_THRESH and
//   deasserts when count < PROG_FULL_THRESH.
// STRUCTURE
// - Shared package/header (accelerator.vh) holds V_ID_WIDTH, V_VALUE_WIDTH and the default
//   FIFO depth/threshold constants. The three named instances bind DATA_WIDTH from there.
// - One sub-module, active_v_fifo_ram: simple dual-port RAM with a synchronous write port
//   and a synchronous registered read port, sized DEPTH x DATA_WIDTH and inferable as
//   distributed/block RAM.
// - The top holds pointers, count, flag decode and the valid register.
// TESTING
// - Reset: hold rst=0 for 3 cycles with wr_en=1 -> empty=1, full=0, prog_full=0, valid=0,
//   dout=0.
// - Single word: write 0xA5 at edge 0; rd_en at edge 1 -> dout=0xA5 and valid=1 after
//   edge 1; empty=1 after edge 1; valid=0 after edge 2.
// - Fill: write 0..31 -> prog_full rises after the 24th write, full after the 32nd. A 33rd
//   write of 0xFF is dropped. Draining returns 0..31 in order, then empty=1.
// - Simultaneous: with count=5, assert wr_en and rd_en together for 40 cycles -> count
//   stays 5 and the output sequence is continuous across pointer wrap.
// - Boundaries: wr+rd while full -> count=31 and the write is dropped; wr+rd while
//   empty -> count=1 and valid=0.
// - Mid-run reset: drop rst with count=10 -> empty=1 next cycle; the next write/read pair
//   returns the new word only.

Source files
------------

// File: rtl/active_v_fifo_pkg.sv
// Shared constants for the first-edge read stage buffers and the FIFO operation encoding.
// The id/edge, value and push-flag FIFOs bind DATA_WIDTH from these constants.
package active_v_fifo_pkg;

  localparam int unsigned V_ID_WIDTH            = 32;
  localparam int unsigned V_VALUE_WIDTH         = 32;
  localparam int unsigned PUSH_FLAG_WIDTH       = 1;
  localparam int unsigned FIFO_ADDR_WIDTH       = 5;
  localparam int unsigned FIFO_PROG_FULL_THRESH = 24;

  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_PUSH = 2'b01,
    FIFO_OP_POP  = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr_ok, input logic rd_ok);
    fifo_op_e op;
    case ({rd_ok, wr_ok})
      2'b01:   op = FIFO_OP_PUSH;
      2'b10:   op = FIFO_OP_POP;
      2'b11:   op = FIFO_OP_BOTH;
      default: op = FIFO_OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/active_v_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// The read register clears on reset and holds when no read is issued.
module active_v_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/active_v_fifo.sv
// Single-clock FIFO with registered read port; prog_full gives early back-pressure
// so BRAM reads already in flight still fit behind the threshold.
module active_v_fifo
  import active_v_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = FIFO_ADDR_WIDTH,
  parameter int unsigned PROG_FULL_THRESH = FIFO_PROG_FULL_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  prog_full
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  wr_ok, rd_ok;
  fifo_op_e              op;

  // Flags decode only the registered count, never wr_en/rd_en.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign prog_full = (count_q >= CNT_W'(PROG_FULL_THRESH));

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign op    = fifo_op(wr_ok, rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = rd_ok;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case (op)
      FIFO_OP_PUSH: count_d = count_q + CNT_W'(1);
      FIFO_OP_POP:  count_d = count_q - CNT_W'(1);
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign valid = valid_q;

  active_v_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_active_v_fifo.sv
// Directed bench for active_v_fifo: reset, single word, fill/drain, simultaneous
// traffic across wrap, full/empty boundaries and mid-run reset.
module tb_active_v_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] dout;
  logic        valid;
  logic        full;
  logic        empty;
  logic        prog_full;

  int unsigned n_cmp;
  int unsigned n_err;

  active_v_fifo #(
    .DATA_WIDTH       (32),
    .ADDR_WIDTH       (5),
    .PROG_FULL_THRESH (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .valid     (valid),
    .full      (full),
    .empty     (empty),
    .prog_full (prog_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0; din = 32'h77;
    repeat (3) tick();
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b want=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b want=0", full); end
    n_cmp++; if (prog_full !== 1'b0) begin n_err++; $display("FAIL reset_prog_full got=%b want=0", prog_full); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid); end
    n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_dout got=%h want=0", dout); end
    rst = 1'b1; wr_en = 1'b0;
    tick();
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_release_empty got=%b want=1", empty); end
  endtask

  task automatic test_single_word();
    wr_en = 1'b1; din = 32'hA5;
    tick();
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_not_empty got=%b want=0", empty); end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    n_cmp++; if (dout !== 32'hA5) begin n_err++; $display("FAIL single_dout got=%h want=a5", dout); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b want=1", valid); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty got=%b want=1", empty); end
    rd_en = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop got=%b want=0", valid); end
    n_cmp++; if (dout !== 32'hA5) begin n_err++; $display("FAIL single_dout_hold got=%h want=a5", dout); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; din = 32'(i);
      tick();
      n_cmp++; if (prog_full !== ((i + 1) >= 24)) begin n_err++; $display("FAIL fill_prog_full[%0d] got=%b want=%b", i, prog_full, ((i + 1) >= 24)); end
      n_cmp++; if (full !== ((i + 1) == 32)) begin n_err++; $display("FAIL fill_full[%0d] got=%b want=%b", i, full, ((i + 1) == 32)); end
    end
    din = 32'hFF;
    tick();
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_overflow_full got=%b want=1", full); end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++; if (dout !== 32'(i)) begin n_err++; $display("FAIL drain_dout[%0d] got=%h want=%h", i, dout, 32'(i)); end
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got=%b want=1", i, valid); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b want=1", empty); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL drain_extra_valid got=%b want=0", valid); end
    n_cmp++; if (dout !== 32'd31) begin n_err++; $display("FAIL drain_extra_dout got=%h want=1f", dout); end
    rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 32'(100 + i);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 32'(105 + k);
      tick();
      n_cmp++; if (dout !== 32'(100 + k) || valid !== 1'b1) begin n_err++; $display("FAIL b2b_dout[%0d] got=%h/%b want=%h/1", k, dout, valid, 32'(100 + k)); end
      n_cmp++; if (empty !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL b2b_flags[%0d] got=e%b f%b want=e0 f0", k, empty, full); end
    end
    wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (dout !== 32'(140 + k)) begin n_err++; $display("FAIL b2b_tail[%0d] got=%h want=%h", k, dout, 32'(140 + k)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got=%b want=1", empty); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_boundaries();
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      din = 32'(200 + i);
      tick();
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL bnd_full got=%b want=1", full); end
    rd_en = 1'b1; din = 32'hEE;
    tick();
    n_cmp++; if (dout !== 32'd200 || valid !== 1'b1) begin n_err++; $display("FAIL bnd_full_rw_dout got=%h/%b want=c8/1", dout, valid); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL bnd_full_rw_count31 got=%b want=0", full); end
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      tick();
      n_cmp++; if (dout !== 32'(200 + i)) begin n_err++; $display("FAIL bnd_drain[%0d] got=%h want=%h", i, dout, 32'(200 + i)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL bnd_drain_empty got=%b want=1", empty); end
    wr_en = 1'b1; din = 32'h55;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL bnd_empty_rw_valid got=%b want=0", valid); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL bnd_empty_rw_count1 got=%b want=0", empty); end
    n_cmp++; if (dout !== 32'd231) begin n_err++; $display("FAIL bnd_empty_rw_hold got=%h want=e7", dout); end
    wr_en = 1'b0;
    tick();
    n_cmp++; if (dout !== 32'h55 || valid !== 1'b1 || empty !== 1'b1) begin n_err++; $display("FAIL bnd_empty_rw_read got=%h/%b/%b want=55/1/1", dout, valid, empty); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_midrun_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 32'(300 + i);
      tick();
    end
    wr_en = 1'b0; rst = 1'b0;
    tick();
    n_cmp++; if (empty !== 1'b1 || valid !== 1'b0 || dout !== 32'h0) begin n_err++; $display("FAIL midrst_state got=%b/%b/%h want=1/0/0", empty, valid, dout); end
    rst = 1'b1; wr_en = 1'b1; din = 32'hBEEF;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    n_cmp++; if (dout !== 32'hBEEF || valid !== 1'b1) begin n_err++; $display("FAIL midrst_read got=%h/%b want=beef/1", dout, valid); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got=%b want=1", empty); end
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    test_reset();
    test_single_word();
    test_fill_drain();
    test_back_to_back();
    test_boundaries();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
